// File: rtl/sqrt_seq_ctrl_if.sv
// Handshake and result bundle for sqrt_seq_ctrl.
// The master requests a root; the slave (the controller) returns status and results.
interface sqrt_seq_ctrl_if;
  logic       start_i;
  logic [7:0] x_i;
  logic       busy_o;
  logic       valid_o;
  logic [3:0] root_o;
  logic [7:0] rem_o;

  modport master (
    output start_i,
    output x_i,
    input  busy_o,
    input  valid_o,
    input  root_o,
    input  rem_o
  );

  modport slave (
    input  start_i,
    input  x_i,
    output busy_o,
    output valid_o,
    output root_o,
    output rem_o
  );
endinterface

// File: rtl/sqrt_seq_ctrl.sv
// Sequential floor(sqrt(x)) by subtracting successive odd numbers through one shared 8-bit CLA.
// Define SQRT_REM_EN to keep a real remainder register on rem_o; otherwise rem_o is tied to zero.
module sqrt_seq_ctrl (
  input  logic           clk_i,
  input  logic           rst_i,
  sqrt_seq_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSub  = 2'd1;
  localparam logic [1:0] StInc  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] r_q, r_d;
  logic [7:0] odd_q, odd_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] root_q;

  logic [7:0] add_a, add_b, add_sum;
  logic       add_ci, add_co;
  logic [4:0] lo_res, hi_res;

  // 4-bit carry-lookahead slice: returns {carry_out, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic ci);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  always_comb begin
    add_a  = 8'd0;
    add_b  = 8'd0;
    add_ci = 1'b0;
    case (state_q)
      StSub: begin
        add_a  = r_q;
        add_b  = ~odd_q;
        add_ci = 1'b1;
      end
      StInc: begin
        add_a = odd_q;
        add_b = 8'd2;
      end
      default: ;
    endcase
  end

  assign lo_res  = cla4(add_a[3:0], add_b[3:0], add_ci);
  assign hi_res  = cla4(add_a[7:4], add_b[7:4], lo_res[4]);
  assign add_sum = {hi_res[3:0], lo_res[3:0]};
  assign add_co  = hi_res[4];

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    odd_d   = odd_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          r_d     = bus.x_i;
          odd_d   = 8'd1;
          cnt_d   = 4'd0;
          state_d = StSub;
        end
      end
      StSub: begin
        // Carry out set means no borrow: remainder still covers the odd subtrahend.
        if (add_co) begin
          r_d     = add_sum;
          cnt_d   = cnt_q + 4'd1;
          state_d = StInc;
        end else begin
          state_d = StDone;
        end
      end
      StInc: begin
        odd_d   = add_sum;
        state_d = StSub;
      end
      default: state_d = StIdle;
    endcase
  end

  logic load_result;
  assign load_result = (state_q == StSub) && !add_co;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      r_q     <= 8'd0;
      odd_q   <= 8'd0;
      cnt_q   <= 4'd0;
      root_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      odd_q   <= odd_d;
      cnt_q   <= cnt_d;
      if (load_result) begin
        root_q <= cnt_q;
      end
    end
  end

`ifdef SQRT_REM_EN
  logic [7:0] rem_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q <= 8'd0;
    end else if (load_result) begin
      rem_q <= r_q;
    end
  end

  assign bus.rem_o = rem_q;
`else
  assign bus.rem_o = 8'd0;
`endif

  assign bus.busy_o  = (state_q != StIdle);
  assign bus.valid_o = (state_q == StDone);
  assign bus.root_o  = root_q;

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Directed bench for sqrt_seq_ctrl: latency, results, ignored starts and mid-run reset.
module tb_sqrt_seq_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sqrt_seq_ctrl_if bus ();

  sqrt_seq_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rem(input logic [31:0] v);
`ifdef SQRT_REM_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present start on the falling edge; returns 1ns into cycle 1 after the accepting edge.
  task automatic do_start(input logic [7:0] v);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.x_i     = v;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.x_i     = 8'($urandom);
  endtask

  // Waits for valid_o with a cycle budget; also flags root_o moving before valid.
  task automatic wait_valid(input string tag, input int exp_cyc, input logic [3:0] exp_root,
                            input logic [7:0] exp_r, input logic [3:0] hold);
    int n;
    logic moved;
    n     = 1;
    moved = 1'b0;
    while (!bus.valid_o && n < 40) begin
      if (bus.root_o !== hold) moved = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_cycle"}, n, exp_cyc);
    chk({tag, "_valid"}, bus.valid_o, 1);
    chk({tag, "_root"}, bus.root_o, exp_root);
    chk({tag, "_rem"}, bus.rem_o, exp_rem(exp_r));
    chk({tag, "_hold"}, moved, 0);
  endtask

  int valid_cnt;
  int valid_cyc;
  logic [3:0] root_at_valid;
  logic [7:0] rem_at_valid;

  initial begin
    checks      = 0;
    errors      = 0;
    bus.start_i = 1'b0;
    bus.x_i     = 8'd0;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_root", bus.root_o, 0);
    chk("rst_rem", bus.rem_o, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // X=0: shortest run, busy only in cycles 1 and 2.
    do_start(8'd0);
    chk("x0_busy_c1", bus.busy_o, 1);
    wait_valid("x0", 2, 4'd0, 8'd0, 4'd0);
    chk("x0_busy_c2", bus.busy_o, 1);
    @(posedge clk);
    #1;
    chk("x0_busy_c3", bus.busy_o, 0);
    chk("x0_valid_c3", bus.valid_o, 0);

    do_start(8'd1);
    wait_valid("x1", 4, 4'd1, 8'd0, 4'd0);
    @(posedge clk);
    #1;

    do_start(8'd200);
    wait_valid("x200", 30, 4'd14, 8'd4, 4'd1);
    @(posedge clk);
    #1;
    chk("x200_root_idle", bus.root_o, 14);
    do_start(8'd255);
    wait_valid("x255", 32, 4'd15, 8'd30, 4'd14);
    @(posedge clk);
    #1;

    // X=100 with stray starts in cycle 3 and in the DONE cycle 22.
    do_start(8'd100);
    valid_cnt     = 0;
    valid_cyc     = 0;
    root_at_valid = 4'd0;
    rem_at_valid  = 8'd0;
    for (int n = 1; n <= 25; n++) begin
      if (bus.valid_o) begin
        valid_cnt++;
        valid_cyc     = n;
        root_at_valid = bus.root_o;
        rem_at_valid  = bus.rem_o;
      end
      bus.start_i = (n == 3 || n == 22);
      bus.x_i     = 8'd9;
      @(posedge clk);
      #1;
    end
    bus.start_i = 1'b0;
    chk("ign_valid_cnt", valid_cnt, 1);
    chk("ign_valid_cyc", valid_cyc, 22);
    chk("ign_root", root_at_valid, 10);
    chk("ign_rem", rem_at_valid, exp_rem(0));
    chk("ign_busy_after", bus.busy_o, 0);

    // Reset in cycle 10 of an X=255 run.
    do_start(8'd255);
    valid_cnt = 0;
    for (int n = 1; n <= 9; n++) begin
      if (bus.valid_o) valid_cnt++;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (bus.valid_o) valid_cnt++;
    chk("rstmid_busy", bus.busy_o, 0);
    chk("rstmid_root", bus.root_o, 0);
    chk("rstmid_rem", bus.rem_o, 0);
    chk("rstmid_novalid", valid_cnt, 0);
    @(posedge clk);
    #1;
    chk("rstmid_idle_busy", bus.busy_o, 0);
    do_start(8'd16);
    wait_valid("x16", 10, 4'd4, 8'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sqrt_seq_ctrl.md
# sqrt_seq_ctrl

Sequential integer square-root controller built around one shared 8-bit carry-lookahead adder: two 4-bit CLA stages chained on the carry, carry-in `Ci_i`, carry-out `Co_o`. The block computes floor(sqrt(X)) for an 8-bit operand by repeated subtraction of successive odd numbers. It time-multiplexes the single adder between the remainder-subtract step and the odd-increment step. It sits between the square-root top level and the adder datapath, owning all sequencing, operand muxing and result registers.

## Interface
- No parameters. Datapath width is fixed at 8 bits to match the shared adder.
- clk_i  input  1  sole clock; all state changes on its rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request a computation; sampled only in IDLE
- x_i  input  8  radicand; captured on the edge that accepts start_i
- busy_o  output  1  high whenever the state is not IDLE
- valid_o  output  1  one-cycle pulse: root_o/rem_o just updated
- root_o  output  4  floor(sqrt(X)), range 0..15
- rem_o  output  8  X - root², range 0..30 (see Configuration)

## Operation
- Internal registers:
  - r: remainder, 8 bits
  - odd: current odd subtrahend, 8 bits
  - cnt: iteration count, 4 bits
  - state: IDLE, SUB, INC, DONE
- One adder instance only. Its operands are muxed by state:
  - SUB: A=r, B=~odd, Ci=1. Sum = r - odd; Co=1 means no borrow, i.e. r ≥ odd.
  - INC: A=odd, B=8'd2, Ci=0.
  - IDLE/DONE: A=0, B=0, Ci=0, and the sum is unused.
- IDLE:
  - If start_i=1: r←x_i, odd←1, cnt←0, go to SUB.
  - Otherwise stay in IDLE.
- SUB:
  - Co=1: r←sum, cnt←cnt+1, go to INC.
  - Co=0: go to DONE. r, odd and cnt are unchanged.
- INC: odd←sum, go to SUB.
- DONE:
  - root_o←cnt and rem_o←r, loaded on the edge entering DONE so they are stable while valid_o=1.
  - valid_o=1 for exactly this one cycle, then return to IDLE.
- Width rules:
  - For X ≤ 255: cnt ≤ 15, odd ≤ 31 and r ≤ 255, so no overflow is possible.
  - cnt increments with a local 4-bit +1. It is never routed through the shared adder.
- start_i in SUB/INC/DONE is ignored. It is not queued; the requester must re-assert it in IDLE.
- x_i is don't-care except on the accepting edge.
- root_o/rem_o hold their last result until the next DONE. They do not change while busy.

## Timing
- Reset values:
  - state=IDLE
  - busy_o=0, valid_o=0
  - root_o=0, rem_o=0
  - r=0, odd=0, cnt=0
- Reset takes priority over every other event. Asserting rst_i mid-computation (any state) forces IDLE on the next edge, discards the operation, clears the outputs, and emits no valid_o.
- Latency: the start is accepted at edge 0 and valid_o is high in cycle 2q+2, where q = result. This comes from q successful SUB+INC pairs, one failing SUB, then DONE.
  - Minimum latency is 2 cycles (X=0).
  - Maximum latency is 32 cycles (X≥225).
- busy_o rises in the cycle after the accepting edge and falls in the cycle after DONE.
- start_i asserted in the same cycle as DONE is ignored. The earliest back-to-back start is accepted in the IDLE cycle following DONE, one idle cycle minimum.

## Configuration
- SQRT_REM_EN defined:
  - rem_o is a real register loaded from r in DONE, as described above.
- SQRT_REM_EN undefined:
  - rem_o is tied to 8'd0 and its register is removed.
  - root_o, valid_o, busy_o and latency are identical to the defined case.

## Test plan
- Reset, then x_i=0 with a start pulse: valid_o is high in cycle 2; root_o=0, rem_o=0; busy_o high in cycles 1–2 only.
- x_i=1: valid_o in cycle 4; root_o=1, rem_o=0.
- x_i=200: valid_o in cycle 30; root_o=14, rem_o=4. Then x_i=255 started in the next IDLE: valid_o in cycle 32; root_o=15, rem_o=30. root_o stays 14 throughout the second computation.
- Start x_i=100, then pulse start_i with x_i=9 in cycles 3 and 22 (the DONE cycle): both pulses are ignored; result is root_o=10, rem_o=0; exactly one valid_o.
- Start x_i=255 and assert rst_i in cycle 10: IDLE next edge; busy_o=0, root_o=0, rem_o=0; no valid_o. A new start with x_i=16 gives root_o=4, rem_o=0 in cycle 10 after its accept.
- Build without SQRT_REM_EN and run x_i=200: root_o=14, rem_o=0, valid_o in cycle 30.
